// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem
// Brief    : EX/MEM pipeline register with stall (hold/bubble) and flush.
//            Optional macro EX_MEM_MADD_EN adds the hilo/cnt MADD/MSUB return
//            path to EX.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [7:0]  mem_aluop,
    output logic [31:0] mem_mem_addr,
    output logic [31:0] mem_reg2
`ifdef EX_MEM_MADD_EN
    ,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
`endif
);

    localparam logic [4:0] c_NOP_REG_ADDR = 5'd0;
    localparam logic [7:0] c_EXE_NOP_OP   = 8'd0;

    logic w_clear;
    logic w_bubble;
    logic w_advance;
    logic w_unused_stall;

    // Flush shares the reset path so it overrides any stall combination.
    assign w_clear        = !rst || flush;
    assign w_bubble       = stall[3] && !stall[4];
    // stall[4] without stall[3] cannot come from ctrl; it simply advances.
    assign w_advance      = !stall[3];
    assign w_unused_stall = &{stall[5], stall[2:0]};

    always_ff @(posedge clk) begin
        if (w_clear || w_bubble) begin
            mem_wd       <= c_NOP_REG_ADDR;
            mem_wreg     <= 1'b0;
            mem_wdata    <= 32'd0;
            mem_whilo    <= 1'b0;
            mem_hi       <= 32'd0;
            mem_lo       <= 32'd0;
            mem_aluop    <= c_EXE_NOP_OP;
            mem_mem_addr <= 32'd0;
            mem_reg2     <= 32'd0;
        end else if (w_advance) begin
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
        end
    end

`ifdef EX_MEM_MADD_EN
    // The accumulate intermediate survives only while EX is stalled.
    always_ff @(posedge clk) begin
        if (w_clear || w_advance) begin
            hilo_o <= 64'd0;
            cnt_o  <= 2'd0;
        end else begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem
// Brief    : Directed self-checking bench for ex_mem (EX_MEM_MADD_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ex_mem;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int n_checks;
    int n_fail;

    logic [174:0] w_mem_all;
    assign w_mem_all = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
                        mem_aluop, mem_mem_addr, mem_reg2};

    ex_mem dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_whilo     (ex_whilo),
        .ex_hi        (ex_hi),
        .ex_lo        (ex_lo),
        .ex_aluop     (ex_aluop),
        .ex_mem_addr  (ex_mem_addr),
        .ex_reg2      (ex_reg2),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2)
`ifdef EX_MEM_MADD_EN
        ,
        .hilo_i       (hilo_i),
        .cnt_i        (cnt_i),
        .hilo_o       (hilo_o),
        .cnt_o        (cnt_o)
`endif
    );

`ifndef EX_MEM_MADD_EN
    assign hilo_o = 64'd0;
    assign cnt_o  = 2'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [4:0] wd, input logic [31:0] wdata);
        ex_wd       = wd;
        ex_wreg     = 1'b1;
        ex_wdata    = wdata;
        ex_whilo    = 1'b1;
        ex_hi       = 32'hDEAD_0001;
        ex_lo       = 32'hBEEF_0002;
        ex_aluop    = 8'hA5;
        ex_mem_addr = 32'h1000_0040;
        ex_reg2     = 32'hCAFE_F00D;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; stall = 6'h3F;
        ex_wd = '1; ex_wreg = 1'b1; ex_wdata = '1; ex_whilo = 1'b1; ex_hi = '1;
        ex_lo = '1; ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1;
        hilo_i = '1; cnt_i = '1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (w_mem_all !== 175'd0) begin
                n_fail++;
                $display("FAIL reset_mem cycle %0d: got %h want 0", c, w_mem_all);
            end
            n_checks++;
            if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_madd cycle %0d: hilo %h cnt %0d want 0", c, hilo_o, cnt_o);
            end
        end
    endtask

    task automatic test_advance();
        @(negedge clk);
        rst = 1'b1; stall = 6'd0; flush = 1'b0;
        drive_ex(5'd5, 32'h1234_5678);
        hilo_i = 64'h1111_2222_3333_4444; cnt_i = 2'd2;
        tick();
        n_checks++;
        if (mem_wd !== 5'd5) begin
            n_fail++; $display("FAIL adv_wd: got %0d want 5", mem_wd);
        end
        n_checks++;
        if (mem_wreg !== 1'b1) begin
            n_fail++; $display("FAIL adv_wreg: got %b want 1", mem_wreg);
        end
        n_checks++;
        if (mem_wdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL adv_wdata: got %h want 12345678", mem_wdata);
        end
        n_checks++;
        if ({mem_whilo, mem_hi, mem_lo} !== {1'b1, 32'hDEAD_0001, 32'hBEEF_0002}) begin
            n_fail++; $display("FAIL adv_hilo_wr: got %b %h %h", mem_whilo, mem_hi, mem_lo);
        end
        n_checks++;
        if ({mem_aluop, mem_mem_addr, mem_reg2} !== {8'hA5, 32'h1000_0040, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL adv_ldst: got %h %h %h", mem_aluop, mem_mem_addr, mem_reg2);
        end
        n_checks++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
            n_fail++; $display("FAIL adv_madd: hilo %h cnt %0d want 0", hilo_o, cnt_o);
        end
        // stall[4] alone must behave as Advance
        @(negedge clk);
        stall = 6'b010000;
        drive_ex(5'd9, 32'h0BAD_CAFE);
        tick();
        n_checks++;
        if (mem_wd !== 5'd9 || mem_wdata !== 32'h0BAD_CAFE) begin
            n_fail++; $display("FAIL adv_illegal_stall: wd %0d wdata %h want 9 0badcafe", mem_wd, mem_wdata);
        end
    endtask

    task automatic test_bubble();
        @(negedge clk);
        stall = 6'b001111;
        drive_ex(5'd3, 32'h7777_7777);
        hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
        tick();
        n_checks++;
        if (w_mem_all !== 175'd0) begin
            n_fail++; $display("FAIL bubble_mem: got %h want 0", w_mem_all);
        end
`ifdef EX_MEM_MADD_EN
        n_checks++;
        if (hilo_o !== 64'h0000_0001_0000_0002 || cnt_o !== 2'd1) begin
            n_fail++; $display("FAIL bubble_madd: hilo %h cnt %0d want 0000000100000002 1", hilo_o, cnt_o);
        end
`endif
        @(negedge clk);
        stall = 6'd0;
        tick();
        n_checks++;
        if (cnt_o !== 2'd0 || hilo_o !== 64'd0) begin
            n_fail++; $display("FAIL bubble_release_madd: hilo %h cnt %0d want 0", hilo_o, cnt_o);
        end
        n_checks++;
        if (mem_wd !== 5'd3 || mem_wdata !== 32'h7777_7777) begin
            n_fail++; $display("FAIL bubble_release_mem: wd %0d wdata %h want 3 77777777", mem_wd, mem_wdata);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        stall = 6'd0;
        drive_ex(5'd4, 32'h0000_00AA);
        tick();
        n_checks++;
        if (mem_wdata !== 32'h0000_00AA) begin
            n_fail++; $display("FAIL hold_load: got %h want aa", mem_wdata);
        end
        @(negedge clk);
        stall = 6'b011111;
        drive_ex(5'd7, 32'h0000_00BB);
        hilo_i = 64'h5555_6666_7777_8888; cnt_i = 2'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (mem_wdata !== 32'h0000_00AA || mem_wd !== 5'd4) begin
                n_fail++; $display("FAIL hold_cycle%0d: wdata %h wd %0d want aa 4", c, mem_wdata, mem_wd);
            end
`ifdef EX_MEM_MADD_EN
            n_checks++;
            if (hilo_o !== 64'h5555_6666_7777_8888 || cnt_o !== 2'd1) begin
                n_fail++; $display("FAIL hold_madd%0d: hilo %h cnt %0d", c, hilo_o, cnt_o);
            end
`endif
        end
    endtask

    task automatic test_flush();
        // Entered from hold: mem_* non-zero, hilo_o loaded.
        @(negedge clk);
        flush = 1'b1;
        tick();
        n_checks++;
        if (w_mem_all !== 175'd0) begin
            n_fail++; $display("FAIL flush_mem: got %h want 0", w_mem_all);
        end
        n_checks++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
            n_fail++; $display("FAIL flush_madd: hilo %h cnt %0d want 0", hilo_o, cnt_o);
        end
        @(negedge clk);
        flush = 1'b0; stall = 6'd0;
        drive_ex(5'd1, 32'h0000_00BB);
        tick();
        n_checks++;
        if (mem_wdata !== 32'h0000_00BB) begin
            n_fail++; $display("FAIL flush_recover: got %h want bb", mem_wdata);
        end
    endtask

    task automatic test_reset_mid_accumulate();
        @(negedge clk);
        stall = 6'b001111;
        hilo_i = 64'hABCD_0000_0000_1234; cnt_i = 2'd1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0 || w_mem_all !== 175'd0) begin
            n_fail++; $display("FAIL reset_mid_acc: hilo %h cnt %0d mem %h want 0", hilo_o, cnt_o, w_mem_all);
        end
        @(negedge clk);
        rst = 1'b1; stall = 6'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_reset_mid_accumulate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
